shift_result_display: RTL and testbench
=======================================

Name: shift_result_display

Overview:
Downstream stage of the 8-bit shift unit. Captures the 8-bit shift result on a load strobe and converts it to three BCD digits with a sequential double-dabble engine. It then drives a 4-digit, time-multiplexed, active-low 7-segment display with optional leading-zero blanking. The last completed value stays on the display while a new conversion runs.

Parameters:
SCAN_DIV, 50000, Clk cycles per displayed digit; legal range >= 1.
LZ_BLANK, 1, 1 = blank leading zeros on hundreds/tens; 0 = always show all three decimal digits.

Ports:
Clk    input   1   system clock; all state changes on rising edge
Rst    input   1   asynchronous, active-high reset
Din    input   8   unsigned value to display (shift-stage result)
Load   input   1   start conversion; sampled on Clk edge, honoured only when Busy=0
Busy   output  1   1 while a conversion is in progress (CONV or DONE state)
Done   output  1   one-cycle pulse; Bcd has just been updated
Bcd    output  12  {hundreds, tens, ones}; each field 4 bits, 0-9
An     output  4   digit enables, active-low one-hot; An[0] = ones digit
Seg    output  7   segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (asynchronous, any time, including mid-conversion):
  - FSM=IDLE, Busy=0, Done=0, Bcd=12'h000.
  - Work registers cleared; prescaler=0; digit index=0.
  - Result: An=4'b1110, Seg=7'b1000000 (shows '0').
  - An aborted conversion never updates Bcd.
- FSM states: IDLE, CONV, DONE.
  - IDLE: when Load=1 at edge E0, latch Din into an 8-bit bin shift register, clear the 12-bit BCD work register, set iteration counter=0, go to CONV. Load=0 keeps IDLE.
  - CONV: one iteration per edge, E1..E8. Each BCD work nibble >=5 gets +3. Then shift {work, bin} left by one bit. Counter increments each iteration.
  - At E8 (8th iteration): Bcd <= final work value; go to DONE.
  - DONE: Done=1 and Busy=1 (Moore outputs) for exactly one cycle; return to IDLE at E9.
- Latency: Load sampled at E0 -> Bcd valid and Done=1 in the cycle after E8. The next Load is accepted at E9 at the earliest.
- Busy=1 in CONV and DONE; 0 only in IDLE.
- Load asserted while Busy=1 (including during DONE) is ignored, not queued. Din changes during a conversion have no effect.
- Bcd holds its previous value for the whole of a conversion; the display never shows partial results.
- Arithmetic:
  - Nibble adjust compares 4-bit values; no carry crosses nibbles.
  - Maximum result is 255 -> Bcd=12'h255; hundreds field is never >2.
- Display scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - At terminal count, digit index advances 0->1->2->3->0.
  - With SCAN_DIV=1 the index advances every cycle.
  - An = ~(4'b0001 << index).
- Digit source per index: 0=ones, 1=tens, 2=hundreds, 3=always blank.
- Leading-zero blanking (LZ_BLANK=1):
  - Hundreds blank when hundreds=0.
  - Tens blank when hundreds=0 and tens=0.
  - Ones never blank.
- Seg encoding (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111; any nibble >9 (unreachable) = blank.
- An and Seg decode only from registered state (index, Bcd), never from Din or the work registers.
- Scanning runs continuously and independently of the conversion FSM. A Bcd update takes effect on the digit currently selected, in the same cycle.

Test Plan:
1. Reset, then Din=8'd255 with a 1-cycle Load at E0 -> Busy=1 from E0 to E9; Done=1 for exactly the cycle after E8; Bcd=12'h255; Busy=0 after E9.
2. Din=8'd0, Load, SCAN_DIV=4, LZ_BLANK=1 -> Bcd=12'h000. Over 16 cycles An steps 1110,1101,1011,0111, each held 4 cycles. Seg=1000000 only when An=1110; 1111111 otherwise.
3. Din=8'd7, then Din=8'd105, each loaded with LZ_BLANK=1 -> 7: tens/hundreds blank, ones=1111000. 105: digits 1,0,5 all shown, tens=1000000. Repeat 7 with LZ_BLANK=0 -> shows 0,0,7.
4. Convert 8'd128, then pulse Load with Din=8'd9 at E3 (CONV) and again during DONE -> both ignored; Bcd=12'h128; exactly one Done pulse.
5. Convert 8'd42 to completion; start 8'd200 and assert Rst at E4 -> Busy=0, Done=0, Bcd=12'h000, An=1110, Seg=1000000 immediately (asynchronous). After release, Load 8'd200 -> Bcd=12'h200 after 9 cycles.
6. Sweep Din=0..255, one Load per value -> every Bcd equals the decimal value of Din. Done count=256; hundreds field never exceeds 2.

Source files
------------

// File: rtl/shift_result_display.sv
// ---------------------------------------------------------------------------
// shift_result_display
//
// Downstream stage of the 8-bit shift unit. A Load strobe captures the shift
// result, a sequential double-dabble engine turns it into three BCD digits
// (eight iterations, one per clock), and the finished value drives a
// four-digit, time-multiplexed, active-low 7-segment display. The display
// keeps showing the last completed value while a new conversion runs.
//
// Parameters:
//   SCAN_DIV  clock cycles each digit stays selected (>= 1)
//   LZ_BLANK  1 = blank leading zeros on hundreds/tens, 0 = show all three
//
// Ports:
//   Clk   in   system clock, rising edge
//   Rst   in   asynchronous active-high reset
//   Din   in   8-bit unsigned value to convert
//   Load  in   start a conversion (honoured only while idle)
//   Busy  out  high while converting or signalling completion
//   Done  out  one-cycle pulse once Bcd has been updated
//   Bcd   out  {hundreds, tens, ones}
//   An    out  active-low one-hot digit enables, An[0] = ones
//   Seg   out  active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module shift_result_display #(
   parameter int SCAN_DIV = 50000,
   parameter bit LZ_BLANK = 1'b1
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [7:0]  Din,
   input  logic        Load,
   output logic        Busy,
   output logic        Done,
   output logic [11:0] Bcd,
   output logic [3:0]  An,
   output logic [6:0]  Seg
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t        state_q, state_d;
   logic [7:0]    binShift_q;
   logic [11:0]   workBcd_q;
   logic [2:0]    iterCnt_q;
   logic [11:0]   bcdOut_q;
   logic [PW-1:0] scanCnt_q;
   logic [1:0]    digitIdx_q;

   logic [11:0]   workAdj;
   logic [11:0]   workNext;
   logic [3:0]    nibble;
   logic          blank;

   // State register for the conversion sequencer
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a Load only starts a conversion from IDLE; eight
   // iterations in CONV, then a single DONE cycle before going idle again
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (Load) state_d = CONV;
         CONV:    if (iterCnt_q == 3'd7) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Moore outputs of the sequencer
   always_comb begin
      Busy = (state_q != IDLE);
      Done = (state_q == DONE);
   end

   // Double-dabble step: each nibble of the work register that is 5 or more
   // gets +3 independently (no carry between nibbles), then {work, bin} is
   // shifted left by one so the next binary MSB enters the ones digit
   always_comb begin
      for (int n = 0; n < 3; n++) begin
         workAdj[n*4 +: 4] = (workBcd_q[n*4 +: 4] >= 4'd5) ?
                             workBcd_q[n*4 +: 4] + 4'd3 : workBcd_q[n*4 +: 4];
      end
      workNext = {workAdj[10:0], binShift_q[7]};
   end

   // Conversion datapath; the visible result register only changes on the
   // last iteration so the display never sees partial values
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         binShift_q <= 8'd0;
         workBcd_q  <= 12'd0;
         iterCnt_q  <= 3'd0;
         bcdOut_q   <= 12'h000;
      end else begin
         case (state_q)
            IDLE: begin
               if (Load) begin
                  binShift_q <= Din;
                  workBcd_q  <= 12'd0;
                  iterCnt_q  <= 3'd0;
               end
            end
            CONV: begin
               workBcd_q  <= workNext;
               binShift_q <= {binShift_q[6:0], 1'b0};
               iterCnt_q  <= iterCnt_q + 3'd1;
               if (iterCnt_q == 3'd7) begin
                  bcdOut_q <= workNext;
               end
            end
            default: ;
         endcase
      end
   end

   // Free-running scan prescaler and digit index, independent of conversion
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         scanCnt_q  <= '0;
         digitIdx_q <= 2'd0;
      end else if (scanCnt_q == SCAN_LAST) begin
         scanCnt_q  <= '0;
         digitIdx_q <= digitIdx_q + 2'd1;
      end else begin
         scanCnt_q  <= scanCnt_q + 1'b1;
      end
   end

   // Digit selection and leading-zero blanking; position 3 is always dark
   always_comb begin
      nibble = 4'd0;
      blank  = 1'b1;
      case (digitIdx_q)
         2'd0: begin
            nibble = bcdOut_q[3:0];
            blank  = 1'b0;
         end
         2'd1: begin
            nibble = bcdOut_q[7:4];
            blank  = LZ_BLANK && (bcdOut_q[11:8] == 4'd0) && (bcdOut_q[7:4] == 4'd0);
         end
         2'd2: begin
            nibble = bcdOut_q[11:8];
            blank  = LZ_BLANK && (bcdOut_q[11:8] == 4'd0);
         end
         default: begin
            nibble = 4'd0;
            blank  = 1'b1;
         end
      endcase
   end

   // Active-low segment decode; codes above 9 fall through to blank
   always_comb begin
      Seg = 7'b1111111;
      if (!blank) begin
         case (nibble)
            4'd0:    Seg = 7'b1000000;
            4'd1:    Seg = 7'b1111001;
            4'd2:    Seg = 7'b0100100;
            4'd3:    Seg = 7'b0110000;
            4'd4:    Seg = 7'b0011001;
            4'd5:    Seg = 7'b0010010;
            4'd6:    Seg = 7'b0000010;
            4'd7:    Seg = 7'b1111000;
            4'd8:    Seg = 7'b0000000;
            4'd9:    Seg = 7'b0010000;
            default: Seg = 7'b1111111;
         endcase
      end
   end

   // Registered-state outputs
   always_comb begin
      An  = ~(4'b0001 << digitIdx_q);
      Bcd = bcdOut_q;
   end

endmodule

// File: tb/tb_shift_result_display.sv
// ---------------------------------------------------------------------------
// tb_shift_result_display
//
// Self-checking bench for shift_result_display. Two instances share the same
// inputs: dutA scans slowly with leading-zero blanking, dutB scans every
// cycle and always shows all three decimal digits.
// ---------------------------------------------------------------------------
module tb_shift_result_display;

   typedef struct {
      logic [7:0]  din;
      logic [11:0] bcd;
      logic [6:0]  aOnes;
      logic [6:0]  aTens;
      logic [6:0]  aHund;
      logic [6:0]  bOnes;
      logic [6:0]  bTens;
      logic [6:0]  bHund;
   } vec_t;

   logic        Clk;
   logic        Rst;
   logic [7:0]  Din;
   logic        Load;

   logic        busyA, doneA, busyB, doneB;
   logic [11:0] bcdA, bcdB;
   logic [3:0]  anA, anB;
   logic [6:0]  segA, segB;

   int checks;
   int errors;
   int doneCount;

   vec_t vecs [8];

   shift_result_display #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) dutA (
      .Clk(Clk), .Rst(Rst), .Din(Din), .Load(Load),
      .Busy(busyA), .Done(doneA), .Bcd(bcdA), .An(anA), .Seg(segA)
   );

   shift_result_display #(.SCAN_DIV(1), .LZ_BLANK(1'b0)) dutB (
      .Clk(Clk), .Rst(Rst), .Din(Din), .Load(Load),
      .Busy(busyB), .Done(doneB), .Bcd(bcdB), .An(anB), .Seg(segB)
   );

   // 10 ns clock
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Done pulses seen on the clock edge that ends each Done cycle
   always @(posedge Clk) begin
      if (doneA) doneCount = doneCount + 1;
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   // One-cycle Load pulse sampled at the next edge (E0)
   task automatic applyStimulus(input logic [7:0] value);
      Din  = value;
      Load = 1'b1;
      tick();
      Load = 1'b0;
   endtask

   // Waits (bounded) for Done after E0; cycles is the number of edges taken
   task automatic waitDone(output int cycles);
      cycles = -1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (doneA) begin
            cycles = c;
            break;
         end
      end
      if (cycles < 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("[TB] FAIL waitDone got timeout expected Done within 20 cycles");
      end
   endtask

   // Waits for a digit position to be scanned and checks its segments
   task automatic checkDigit(input bit useB, input int idx, input logic [6:0] exp, input string name);
      logic [3:0] want;
      bit found;
      want  = ~(4'b0001 << idx);
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if ((useB ? anB : anA) == want) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      if (!found) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("[TB] FAIL %s got no scan of digit %0d expected An=%b", name, idx, want);
      end else begin
         checkOutput(name, useB ? segB : segA, exp);
      end
   endtask

   initial begin
      int cyc;
      int dc;
      logic [3:0] h, t, o;
      logic [3:0] prevAn;
      logic [3:0] expAn;

      checks    = 0;
      errors    = 0;
      doneCount = 0;
      Rst  = 1'b1;
      Load = 1'b0;
      Din  = 8'd0;

      //           din     bcd      A: ones   tens   hund    B: ones   tens   hund
      vecs[0] = '{8'd0,   12'h000, 7'h40, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40};
      vecs[1] = '{8'd7,   12'h007, 7'h78, 7'h7F, 7'h7F, 7'h78, 7'h40, 7'h40};
      vecs[2] = '{8'd105, 12'h105, 7'h12, 7'h40, 7'h79, 7'h12, 7'h40, 7'h79};
      vecs[3] = '{8'd255, 12'h255, 7'h12, 7'h12, 7'h24, 7'h12, 7'h12, 7'h24};
      vecs[4] = '{8'd42,  12'h042, 7'h24, 7'h19, 7'h7F, 7'h24, 7'h19, 7'h40};
      vecs[5] = '{8'd200, 12'h200, 7'h40, 7'h40, 7'h24, 7'h40, 7'h40, 7'h24};
      vecs[6] = '{8'd10,  12'h010, 7'h40, 7'h79, 7'h7F, 7'h40, 7'h79, 7'h40};
      vecs[7] = '{8'd99,  12'h099, 7'h10, 7'h10, 7'h7F, 7'h10, 7'h10, 7'h40};

      // Reset state
      #3;
      checkOutput("rstBusy", busyA, 1'b0);
      checkOutput("rstDone", doneA, 1'b0);
      checkOutput("rstBcd", bcdA, 12'h000);
      checkOutput("rstAn", anA, 4'b1110);
      checkOutput("rstSeg", segA, 7'b1000000);
      checkOutput("rstAnB", anB, 4'b1110);
      @(negedge Clk);
      Rst = 1'b0;
      tick();

      // Full-scale conversion with cycle-accurate Busy/Done
      applyStimulus(8'd255);
      checkOutput("t1BusyE0", busyA, 1'b1);
      checkOutput("t1DoneE0", doneA, 1'b0);
      for (int e = 1; e <= 7; e++) begin
         tick();
         checkOutput("t1BusyConv", busyA, 1'b1);
         checkOutput("t1DoneConv", doneA, 1'b0);
         checkOutput("t1BcdHeld", bcdA, 12'h000);
      end
      tick();
      checkOutput("t1DoneE8", doneA, 1'b1);
      checkOutput("t1BusyE8", busyA, 1'b1);
      checkOutput("t1Bcd", bcdA, 12'h255);
      tick();
      checkOutput("t1BusyE9", busyA, 1'b0);
      checkOutput("t1DoneE9", doneA, 1'b0);

      // Table of values: result plus each digit on both display flavours
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].din);
         waitDone(cyc);
         checkOutput("vecBcd", bcdA, {20'd0, vecs[i].bcd});
         checkOutput("vecBcdB", bcdB, {20'd0, vecs[i].bcd});
         tick();
         checkDigit(1'b0, 0, vecs[i].aOnes, "vecAOnes");
         checkDigit(1'b0, 1, vecs[i].aTens, "vecATens");
         checkDigit(1'b0, 2, vecs[i].aHund, "vecAHund");
         checkDigit(1'b0, 3, 7'h7F, "vecABlank3");
         checkDigit(1'b1, 0, vecs[i].bOnes, "vecBOnes");
         checkDigit(1'b1, 1, vecs[i].bTens, "vecBTens");
         checkDigit(1'b1, 2, vecs[i].bHund, "vecBHund");
         checkDigit(1'b1, 3, 7'h7F, "vecBBlank3");
      end

      // Scan sequence for zero: each digit held 4 cycles, only ones lit
      applyStimulus(8'd0);
      waitDone(cyc);
      tick();
      for (int c = 0; c < 20; c++) begin
         prevAn = anA;
         tick();
         if (prevAn != 4'b1110 && anA == 4'b1110) break;
      end
      for (int k = 0; k < 16; k++) begin
         expAn = ~(4'b0001 << (k / 4));
         checkOutput("scanAn", anA, expAn);
         checkOutput("scanSeg", segA, (k < 4) ? 7'b1000000 : 7'b1111111);
         tick();
      end

      // Loads during CONV and DONE are dropped
      dc = 0;
      applyStimulus(8'd128);
      tick(); dc += doneA;
      tick(); dc += doneA;
      Din  = 8'd9;
      Load = 1'b1;
      tick(); dc += doneA;
      Load = 1'b0;
      Din  = 8'd0;
      for (int e = 4; e <= 8; e++) begin
         tick(); dc += doneA;
      end
      checkOutput("t4DoneE8", doneA, 1'b1);
      checkOutput("t4Bcd", bcdA, 12'h128);
      Din  = 8'd9;
      Load = 1'b1;
      tick();
      Load = 1'b0;
      checkOutput("t4BusyE9", busyA, 1'b0);
      for (int c = 0; c < 12; c++) begin
         tick(); dc += doneA;
      end
      checkOutput("t4DoneCount", dc, 1);
      checkOutput("t4BcdKept", bcdA, 12'h128);
      checkOutput("t4Idle", busyA, 1'b0);

      // Asynchronous reset in the middle of a conversion
      applyStimulus(8'd42);
      waitDone(cyc);
      tick();
      checkOutput("t5Bcd42", bcdA, 12'h042);
      applyStimulus(8'd200);
      tick();
      tick();
      tick();
      @(posedge Clk);
      Rst = 1'b1;
      #1;
      checkOutput("t5RstBusy", busyA, 1'b0);
      checkOutput("t5RstDone", doneA, 1'b0);
      checkOutput("t5RstBcd", bcdA, 12'h000);
      checkOutput("t5RstAn", anA, 4'b1110);
      checkOutput("t5RstSeg", segA, 7'b1000000);
      @(negedge Clk);
      Rst = 1'b0;
      tick();
      applyStimulus(8'd200);
      waitDone(cyc);
      checkOutput("t5Latency", cyc, 8);
      checkOutput("t5Bcd200", bcdA, 12'h200);
      tick();

      // Exhaustive sweep against a decimal model
      doneCount = 0;
      for (int d = 0; d < 256; d++) begin
         h = 4'(d / 100);
         t = 4'((d / 10) % 10);
         o = 4'(d % 10);
         applyStimulus(8'(d));
         waitDone(cyc);
         checkOutput("sweepBcd", bcdA, {20'd0, h, t, o});
         checkOutput("sweepHundMax", (bcdA[11:8] <= 4'd2), 1'b1);
         tick();
      end
      checkOutput("sweepDoneCount", doneCount, 256);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time limit so the bench always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got timeout expected completion");
      errors = errors + 1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
